// File: rtl/serial_updown_ctrl_pkg.sv
// Shared definitions for the bit-serial up/down counter controller:
// FSM state encoding and the bit-index width helper.
package serial_updown_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bit-index width for a given operand width (at least one bit).
  function automatic int unsigned idx_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned IDX_W = idx_w(WIDTH_DEF);

endpackage

// File: rtl/serial_updown_ctrl_fulladder.sv
// One-bit full adder shared by the serial datapath.
//   a, b, c : addend bits and carry-in
//   s, ca   : sum and carry-out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic ca
);

  assign s  = a ^ b ^ c;
  assign ca = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_updown_ctrl.sv
// Bit-serial up/down counter controller. Streams count and step through a
// single full adder LSB-first over WIDTH cycles, then commits the result.
// Loads bypass the adder and commit on the accepting edge.
//   clk, rst_n           : clock, async active-low reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_load/req_up      : load, or add (up) / subtract (down)
//   req_data             : step or load value
//   count, wrap          : committed value and last-op wrap/borrow flag
//   busy, done           : op in flight; one-cycle completion pulse
module serial_updown_ctrl
  import serial_updown_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_load,
  input  logic             req_up,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IW = idx_w(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             fa_s, fa_ca;
  logic             last_bit;

  // Subtraction is add of the inverted step with carry-in 1.
  fulladder u_fa (
    .a  (acc_q[0]),
    .b  (op_q[0] ^ sub_q),
    .c  (carry_q),
    .s  (fa_s),
    .ca (fa_ca)
  );

  assign last_bit = (idx_q == IW'(WIDTH - 1));

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    op_d    = op_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    wrap_d  = wrap_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_load) begin
            count_d = req_data;
            wrap_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            acc_d   = count_q;
            op_d    = req_data;
            sub_d   = ~req_up;
            carry_d = ~req_up;
            idx_d   = '0;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        carry_d = fa_ca;
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        op_d    = op_q >> 1;
        idx_d   = idx_q + IW'(1);
        if (last_bit) begin
          count_d = {fa_s, acc_q[WIDTH-1:1]};
          // Down: no carry-out of the complemented add means a borrow.
          wrap_d  = sub_q ? ~fa_ca : fa_ca;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign count     = count_q;
  assign wrap      = wrap_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_updown_ctrl.sv
// Scoreboard bench for serial_updown_ctrl (WIDTH=8). Accepted requests push
// an expected {count, wrap, latency} entry; a monitor pops it on every done.
module tb_serial_updown_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_load;
  logic         req_up;
  logic [W-1:0] req_data;
  logic [W-1:0] count;
  logic         wrap;
  logic         busy;
  logic         done;

  serial_updown_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_load  (req_load),
    .req_up    (req_up),
    .req_data  (req_data),
    .count     (count),
    .wrap      (wrap),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] c;
    logic         w;
    int           acc;
    logic         ld;
  } exp_t;

  exp_t         sb[$];
  int           acc_log[$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_bad = 0;
  logic [W-1:0] m_count = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: applied at every accepting edge.
  always @(posedge clk) begin
    exp_t e;
    logic [W:0] sum;
    cyc++;
    if (rst_n && req_valid && req_ready) begin
      e.acc = cyc;
      e.ld  = req_load;
      if (req_load) begin
        m_count = req_data;
        e.w     = 1'b0;
      end else if (req_up) begin
        sum     = {1'b0, m_count} + {1'b0, req_data};
        m_count = sum[W-1:0];
        e.w     = sum[W];
      end else begin
        e.w     = (req_data > m_count);
        m_count = m_count - req_data;
      end
      e.c = m_count;
      sb.push_back(e);
      acc_log.push_back(cyc);
    end
  end

  // Monitor: result and latency on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("count", 32'(count), 32'(e.c));
        chk("wrap", 32'(wrap), 32'(e.w));
        chk("latency", 32'(cyc - e.acc), e.ld ? 32'(0) : 32'(W));
      end
    end
  end

  task automatic op(input logic l, input logic u, input logic [W-1:0] d);
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 32'(req_ready), 32'(1));
    req_valid = 1'b1;
    req_load  = l;
    req_up    = u;
    req_data  = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!(req_ready && sb.size() == 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", 32'(req_ready && sb.size() == 0), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int t;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_up    = 1'b0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_wrap", 32'(wrap), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rst_n = 1'b1;

    // 0xFE + 1 -> 0xFF, then 0xFF + 1 -> 0x00 with wrap; count holds until commit.
    op(1'b1, 1'b0, 8'hFE);
    op(1'b0, 1'b1, 8'h01);
    wait_idle();
    chk("pre_ff", 32'(count), 32'hFF);
    op(1'b0, 1'b1, 8'h01);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("hold_ff", 32'(count), 32'hFF);
      chk("hold_busy", 32'(busy), 32'(1));
    end
    wait_idle();

    // 0x00 - 1 -> 0xFF borrow; 0x50 - 0x20 -> 0x30; zero steps.
    op(1'b0, 1'b0, 8'h01);
    op(1'b1, 1'b0, 8'h50);
    op(1'b0, 1'b0, 8'h20);
    op(1'b0, 1'b1, 8'h00);
    op(1'b0, 1'b0, 8'h00);
    wait_idle();
    chk("after_zero", 32'(count), 32'h30);
    chk("after_zero_wrap", 32'(wrap), 32'(0));

    // Async reset in the middle of SHIFT (idx 4) drops the op.
    op(1'b0, 1'b1, 8'h03);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'(0));
    chk("midrst_wrap", 32'(wrap), 32'(0));
    chk("midrst_ready", 32'(req_ready), 32'(1));
    chk("midrst_busy", 32'(busy), 32'(0));
    sb.delete();
    m_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("postrst_count", 32'(count), 32'(0));
    chk("postrst_done", 32'(done), 32'(0));

    // req_valid held high: three +5 ops, garbage data while busy.
    n0 = acc_log.size();
    t  = 0;
    req_valid = 1'b1;
    req_load  = 1'b0;
    req_up    = 1'b1;
    while (acc_log.size() < n0 + 3 && t < 100) begin
      req_data = req_ready ? 8'h05 : 8'($urandom);
      @(negedge clk);
      t++;
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(acc_log.size() - n0), 32'(3));
    if (acc_log.size() >= n0 + 3) begin
      chk("b2b_gap1", 32'(acc_log[n0+1] - acc_log[n0]), 32'(W + 2));
      chk("b2b_gap2", 32'(acc_log[n0+2] - acc_log[n0+1]), 32'(W + 2));
    end
    wait_idle();
    chk("b2b_count", 32'(count), 32'h0F);

    // Random mix against the reference model.
    for (int i = 0; i < 1000; i++) begin
      op(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    wait_idle();
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
